uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver: the next generation of the team's fixed 8N1 receiver. It adds 16x oversampling with majority-vote sampling, selectable data width, parity and stop bits, glitch and break detection, and a first-word-fall-through receive FIFO with a ready/valid output. It sits between the synchronised serial pin and the host-side register/bus logic.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit; fixed legal value 16.
- DATA_BITS, 8: payload bits per frame; legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2, ≥ 2.
- clk  in  1  system clock.
- rst_  in  1  reset, asynchronous, active-low.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_data  out  8  FIFO head payload; bits above DATA_BITS-1 read 0.
- rx_frame_err  out  1  FIFO head sideband: stop bit sampled 0.
- rx_parity_err  out  1  FIFO head sideband: parity mismatch.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- rx_overrun  out  1  sticky: a frame arrived while the FIFO was full.
- clear_overrun  in  1  one-cycle pulse clears rx_overrun.
- rx_break  out  1  one-cycle pulse: break condition detected.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held.

## Operation
- rx_serial passes through a 2-FF synchroniser; all logic uses the synchronised value.
- Tick generator: counter with modulus TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE). It emits a one-cycle tick and wraps to 0. Minimum TICK_DIV is 1 (tick every cycle). The counter is reset to 0 on start-edge detection.
- Bit sample: a 4-bit tick counter runs per bit. The bit value is the majority of the samples taken at ticks 7, 8 and 9. The bit completes at tick 15.
- States:
  - IDLE: wait for the synchronised line to go 1→0, then enter START.
  - START: if the majority sample is 1, treat the edge as a glitch and return to IDLE with no flag. Otherwise enter DATA.
  - DATA: shift DATA_BITS bits, LSB first. Go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample the parity bit. Odd parity requires the XOR of data and parity to be 1; even parity requires it to be 0.
  - STOP: sample STOP_BITS bits. Any 0 sets the framing error.
  - Frame completion is at the majority decision of the last stop bit (tick 9), not tick 15, so back-to-back frames are never missed. Then return to IDLE.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0. On break:
  - pulse rx_break;
  - push no frame;
  - enter WAIT_IDLE until the line is sampled 1, then go to IDLE.
- Push rules:
  - Non-break frames, including those with errors, are pushed with their sideband flags.
  - If the FIFO is full and no pop occurs in the same cycle, drop the frame and set rx_overrun.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Overrun: rx_overrun stays set until clear_overrun. If clear_overrun and a new overrun coincide, the set wins.
- FIFO: first-word-fall-through. rx_data and the sideband flags are valid whenever rx_valid = 1 and hold stable until popped. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: rx_data 0, rx_frame_err 0, rx_parity_err 0, rx_valid 0, rx_overrun 0, rx_break 0, fifo_count 0. FSM in IDLE, all counters 0, synchroniser flops 1. Reset mid-frame discards the partial frame and the FIFO contents.
- Latency, start edge on pin to edge detection: 3 clk (2 synchroniser + 1 edge register).
- Frame completion to rx_valid (FIFO empty case): rx_valid and fifo_count update on the clock edge after the push cycle.
- Pop: when rx_valid && rx_ready at edge N, the next entry (or rx_valid = 0) appears after edge N. Zero-cycle bubble for back-to-back pops.
- rx_break: high for exactly 1 clk, in the cycle after the break decision.
- Sustained input at full baud is handled with no inter-frame idle; baud mismatch tolerance is ±3 %.

## Test plan
- 16 MHz / 1 Mbaud (TICK_DIV = 1), 8N1, send 0xA5 → rx_valid after completion; rx_data 0xA5; both error flags 0; fifo_count 1.
- DATA_BITS=7, PARITY=2, STOP_BITS=2: send 0x5A with correct parity, then 0x5A with parity flipped → entries 0x5A/perr 0, then 0x5A/perr 1.
- 8N1, frame 0x3C with stop bit driven 0 → entry 0x3C with rx_frame_err 1, no rx_break. A 4-clk low glitch on the idle line → no entry, FSM back in IDLE.
- Line held low for 2 frame times → exactly one rx_break pulse, no FIFO entry. After the line returns high, 0x11 is received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 5 back-to-back frames 0x01..0x05:
  - fifo_count saturates at 4;
  - rx_overrun is set and 0x05 is dropped;
  - popping yields 0x01..0x04;
  - clear_overrun clears the flag.
- Assert rst_ low mid-DATA of frame 0x77 while the FIFO holds 2 entries → all outputs 0 and the FIFO empty. The next clean frame 0x88 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// uart_rx_cfg: configurable UART receiver with 16x oversampling, majority-vote sampling,
// parity/stop checking, glitch and break detection, and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_,
  input  logic                            rx_serial,
  output logic [7:0]                      rx_data,
  output logic                            rx_frame_err,
  output logic                            rx_parity_err,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            rx_overrun,
  input  logic                            clear_overrun,
  output logic                            rx_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_WAIT  = 3'd5
  } state_e;

  logic          sync1_q, sync2_q, prev_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick, start_edge, mid, last, maj, perr, brk_cond;
  state_e        state_q;
  logic [3:0]    samp_q;
  logic          s0_q, s1_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    shreg_q;
  logic          par_q, ferr_q;
  logic          push_q, brk_q;
  logic [9:0]    push_word_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge = (state_q == S_IDLE) && prev_q && !sync2_q;
  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Restarting the divider on the start edge aligns the sample points to the bit centre.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tick_cnt_q <= '0;
    end else if (start_edge || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  assign mid  = tick && (samp_q == 4'd9);
  assign last = tick && (samp_q == 4'd15);
  assign maj  = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

  always_comb begin
    perr = 1'b0;
    if (PARITY == 1) begin
      perr = ~(^shreg_q ^ par_q);
    end else if (PARITY == 2) begin
      perr = ^shreg_q ^ par_q;
    end
  end

  assign brk_cond = (shreg_q == 8'd0) && ((PARITY == 0) || !par_q) && !maj;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      samp_q      <= 4'd0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      shreg_q     <= 8'd0;
      par_q       <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= 10'd0;
      brk_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      brk_q  <= 1'b0;
      if (tick && (state_q != S_IDLE) && (state_q != S_WAIT)) begin
        samp_q <= samp_q + 4'd1;
        if (samp_q == 4'd7) s0_q <= sync2_q;
        if (samp_q == 4'd8) s1_q <= sync2_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q    <= S_START;
            samp_q     <= 4'd0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shreg_q    <= 8'd0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        S_START: begin
          if (mid && maj) begin
            state_q <= S_IDLE;
          end else if (last) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (mid) shreg_q[bit_idx_q] <= maj;
          if (last) begin
            if (bit_idx_q == LAST_BIT) begin
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        S_PAR: begin
          if (mid) par_q <= maj;
          if (last) state_q <= S_STOP;
        end
        S_STOP: begin
          // The frame completes at the last stop bit's decision so a back-to-back start is caught.
          if (mid) begin
            if (!stop_idx_q && brk_cond) begin
              brk_q   <= 1'b1;
              state_q <= S_WAIT;
            end else if (stop_idx_q == LAST_STOP) begin
              push_q      <= 1'b1;
              push_word_q <= {perr, ferr_q | ~maj, shreg_q};
              state_q     <= S_IDLE;
            end else begin
              ferr_q <= ferr_q | ~maj;
            end
          end
          if (last) stop_idx_q <= 1'b1;
        end
        S_WAIT: begin
          if (sync2_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, full, pop, push_ok;
  logic [9:0]    head;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rx_valid && rx_ready;
  assign push_ok = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word_q;
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (push_q && full && !pop) begin
        ovr_q <= 1'b1;
      end else if (clear_overrun) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rx_valid      = (count_q != '0);
  assign rx_data       = rx_valid ? head[7:0] : 8'd0;
  assign rx_frame_err  = rx_valid & head[8];
  assign rx_parity_err = rx_valid & head[9];
  assign rx_overrun    = ovr_q;
  assign rx_break      = brk_q;
  assign fifo_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// tb_uart_rx_cfg: randomized scoreboard bench for two receiver configurations (8N1 and 7E2, 4-deep FIFO).
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic            clk;
  logic            rst_;
  logic [1:0]      ser, rdy, clr;
  wire  [1:0][7:0] rdata;
  wire  [1:0]      fe, pe, vld, ovr, brk;
  wire  [1:0][2:0] cnt;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   brk_cnt[2];
  int   brkrun[2];
  int   mon_qs;
  exp_t mon_e;

  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_(rst_), .rx_serial(ser[0]), .rx_data(rdata[0]), .rx_frame_err(fe[0]),
    .rx_parity_err(pe[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_overrun(ovr[0]),
    .clear_overrun(clr[0]), .rx_break(brk[0]), .fifo_count(cnt[0]));

  uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_(rst_), .rx_serial(ser[1]), .rx_data(rdata[1]), .rx_frame_err(fe[1]),
    .rx_parity_err(pe[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_overrun(ovr[1]),
    .clear_overrun(clr[1]), .rx_break(brk[1]), .fifo_count(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int nb(input int i);  return (i == 1) ? 7 : 8; endfunction
  function automatic int par(input int i); return (i == 1) ? 2 : 0; endfunction
  function automatic int sb(input int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic int qsize(input int i); return (i == 1) ? q1.size() : q0.size(); endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic b, input int n);
    ser[idx] = b;
    wait_clk(n);
  endtask

  // Reference model: the frame is built from the line-format rules and the expected FIFO entry
  // (or break) is derived from what was actually put on the wire.
  task automatic send_frame(input int idx, input logic [7:0] d, input bit pflip,
                            input bit [1:0] stopz, input bit exp_push);
    logic [7:0] dm;
    logic       pb;
    exp_t       e;
    bit         is_brk;
    dm = d & (8'hFF >> (8 - nb(idx)));
    pb = (par(idx) == 1) ? ~(^dm) : (^dm);
    pb = pb ^ pflip;
    e.d  = dm;
    e.fe = stopz[0] | ((sb(idx) == 2) && stopz[1]);
    case (par(idx))
      1:       e.pe = ((^dm ^ pb) != 1'b1);
      2:       e.pe = ((^dm ^ pb) != 1'b0);
      default: e.pe = 1'b0;
    endcase
    is_brk = (dm == 8'd0) && ((par(idx) == 0) || !pb) && stopz[0];
    if (exp_push && !is_brk) begin
      if (idx == 1) q1.push_back(e);
      else          q0.push_back(e);
    end
    drive(idx, 1'b0, 16);
    for (int i = 0; i < nb(idx); i++) drive(idx, dm[i], 16);
    if (par(idx) != 0) drive(idx, pb, 16);
    for (int i = 0; i < sb(idx); i++) drive(idx, ~stopz[i], 16);
    if (stopz[sb(idx) - 1]) drive(idx, 1'b1, 16);
  endtask

  task automatic drain(input int idx);
    int k = 0;
    rdy[idx] = 1'b1;
    while (qsize(idx) != 0 && k < 3000) begin
      wait_clk(1);
      k++;
    end
    wait_clk(2);
    check($sformatf("drain%0d", idx), qsize(idx), 0);
  endtask

  task automatic wait_valid(input int idx);
    int k = 0;
    while (!vld[idx] && k < 60) begin
      wait_clk(1);
      k++;
    end
    check($sformatf("wait_valid%0d", idx), int'(vld[idx]), 1);
  endtask

  task automatic check_cleared(input int i, input string tag);
    check($sformatf("%s_valid%0d", tag, i), int'(vld[i]), 0);
    check($sformatf("%s_count%0d", tag, i), int'(cnt[i]), 0);
    check($sformatf("%s_data%0d", tag, i), int'(rdata[i]), 0);
    check($sformatf("%s_ferr%0d", tag, i), int'(fe[i]), 0);
    check($sformatf("%s_perr%0d", tag, i), int'(pe[i]), 0);
    check($sformatf("%s_ovr%0d", tag, i), int'(ovr[i]), 0);
    check($sformatf("%s_brk%0d", tag, i), int'(brk[i]), 0);
  endtask

  task automatic random_frames(input int idx, input int n);
    logic [7:0] d;
    bit [1:0]   sz;
    bit         pf;
    for (int k = 0; k < n; k++) begin
      d  = 8'($urandom);
      sz = 2'b00;
      if ($urandom_range(0, 4) == 0) sz[0] = 1'b1;
      if (sb(idx) == 2 && $urandom_range(0, 4) == 0) sz[1] = 1'b1;
      pf = (par(idx) != 0) && ($urandom_range(0, 3) == 0);
      if ((d & (8'hFF >> (8 - nb(idx)))) == 8'd0) sz = 2'b00;
      rdy[idx] = (cnt[idx] >= 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(idx, d, pf, sz, 1'b1);
      if ($urandom_range(0, 1) == 1) drive(idx, 1'b1, int'($urandom_range(1, 20)));
    end
    drain(idx);
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && rdy[i]) begin
          mon_qs = qsize(i);
          check($sformatf("sb_has_entry%0d", i), int'(mon_qs > 0), 1);
          if (mon_qs > 0) begin
            if (i == 1) mon_e = q1.pop_front();
            else        mon_e = q0.pop_front();
            check($sformatf("pop_data%0d", i), int'(rdata[i]), int'(mon_e.d));
            check($sformatf("pop_ferr%0d", i), int'(fe[i]), int'(mon_e.fe));
            check($sformatf("pop_perr%0d", i), int'(pe[i]), int'(mon_e.pe));
          end
        end
        if (brk[i]) begin
          brkrun[i]++;
        end else if (brkrun[i] > 0) begin
          check($sformatf("break_width%0d", i), brkrun[i], 1);
          brk_cnt[i]++;
          brkrun[i] = 0;
        end
      end
    end
  end

  initial begin
    int b0;
    rst_ = 1'b0;
    ser  = 2'b11;
    rdy  = 2'b00;
    clr  = 2'b00;
    wait_clk(5);
    for (int i = 0; i < 2; i++) check_cleared(i, "reset");
    rst_ = 1'b1;
    wait_clk(5);

    // 8N1 single frame held in the FIFO, then popped
    send_frame(0, 8'hA5, 1'b0, 2'b00, 1'b1);
    wait_valid(0);
    check("a5_count", int'(cnt[0]), 1);
    check("a5_data", int'(rdata[0]), 'hA5);
    check("a5_ferr", int'(fe[0]), 0);
    check("a5_perr", int'(pe[0]), 0);
    drain(0);

    // framing error is pushed, not reported as break
    b0 = brk_cnt[0];
    send_frame(0, 8'h3C, 1'b0, 2'b01, 1'b1);
    drain(0);
    check("ferr_no_break", brk_cnt[0] - b0, 0);

    // short glitch on idle line
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check("glitch_count", int'(cnt[0]), 0);
    check("glitch_valid", int'(vld[0]), 0);
    check("glitch_no_break", brk_cnt[0] - b0, 0);
    send_frame(0, 8'h96, 1'b0, 2'b00, 1'b1);
    drain(0);

    // break: line low for two frame times
    b0 = brk_cnt[0];
    drive(0, 1'b0, 320);
    drive(0, 1'b1, 32);
    check("break_pulses", brk_cnt[0] - b0, 1);
    check("break_no_entry", int'(vld[0]), 0);
    send_frame(0, 8'h11, 1'b0, 2'b00, 1'b1);
    drain(0);

    random_frames(0, 24);

    // overrun: 5 back-to-back frames into a 4-deep FIFO
    rdy[0] = 1'b0;
    check("ovr_before", int'(ovr[0]), 0);
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 2'b00, k <= 4);
    wait_clk(8);
    check("ovr_count", int'(cnt[0]), 4);
    check("ovr_set", int'(ovr[0]), 1);
    check("ovr_head", int'(rdata[0]), 1);
    drain(0);
    check("ovr_sticky", int'(ovr[0]), 1);
    clr[0] = 1'b1;
    wait_clk(1);
    clr[0] = 1'b0;
    check("ovr_cleared", int'(ovr[0]), 0);

    // reset mid-frame with two entries queued
    rdy[0] = 1'b0;
    send_frame(0, 8'h21, 1'b0, 2'b00, 1'b0);
    send_frame(0, 8'h42, 1'b0, 2'b00, 1'b0);
    wait_clk(4);
    check("pre_reset_count", int'(cnt[0]), 2);
    fork
      send_frame(0, 8'h77, 1'b0, 2'b00, 1'b0);
      begin
        wait_clk(64);
        rst_ = 1'b0;
        #2;
        check_cleared(0, "midreset");
      end
    join
    wait_clk(2);
    rst_ = 1'b1;
    wait_clk(4);
    check("post_reset_count", int'(cnt[0]), 0);
    send_frame(0, 8'h88, 1'b0, 2'b00, 1'b1);
    drain(0);

    // 7E2: good parity, flipped parity, second stop bit low
    rdy[1] = 1'b1;
    send_frame(1, 8'h5A, 1'b0, 2'b00, 1'b1);
    send_frame(1, 8'h5A, 1'b1, 2'b00, 1'b1);
    send_frame(1, 8'h33, 1'b0, 2'b10, 1'b1);
    drain(1);
    b0 = brk_cnt[1];
    drive(1, 1'b0, 400);
    drive(1, 1'b1, 32);
    check("break_pulses1", brk_cnt[1] - b0, 1);
    check("break_no_entry1", int'(vld[1]), 0);
    random_frames(1, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
